// File: rtl/ir_rx_pkg.sv
// ir_rx_pkg: shared state encoding, default timing and bit-index helper for IR receivers
package ir_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, ALIGN, DATA, DONE, ERR} state_t;

    localparam int DEF_DATA_BITS     = 11;
    localparam int DEF_START_EDGES   = 3;
    localparam int DEF_HALF_CYCLES   = 44500;
    localparam int DEF_BIT_CYCLES    = 89000;
    localparam int DEF_WIN_LO        = 30000;
    localparam int DEF_WIN_HI        = 60000;
    localparam int DEF_START_TIMEOUT = 200000;

    function automatic int idx(input int k, input int n, input int lsb_first);
        return (lsb_first != 0) ? k : n - 1 - k;
    endfunction

endpackage

// File: rtl/ir_frame_receiver_if.sv
// ir_frame_receiver_if: IR pin input and frame result outputs of the receiver
interface ir_frame_receiver_if #(
    parameter int DATA_BITS = 11
);
    logic                 sda;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_error;
    logic [4:0]           err_bit;
    logic                 busy;

    modport master (input sda, output rx_data, rx_valid, rx_error, err_bit, busy);
    modport slave (output sda, input rx_data, rx_valid, rx_error, err_bit, busy);
endinterface

// File: rtl/ir_edge_sync.sv
// ir_edge_sync: two-flop synchroniser for an idle-high pin with fall/rise pulses
module ir_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic fall,
    output logic rise
);
    logic [1:0] s;

    // shift the pin in; reset to the idle-high level so no false edge follows reset
    always_ff @(posedge clk or negedge rst)
        if (!rst) s <= 2'b11;
        else      s <= {s[0], d};

    assign fall = s == 2'b10;
    assign rise = s == 2'b01;
endmodule

// File: rtl/ir_frame_receiver.sv
// ir_frame_receiver: preamble-counting, mid-bit aligned IR frame decoder that re-arms per frame
module ir_frame_receiver
    import ir_rx_pkg::*;
#(
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int START_EDGES   = DEF_START_EDGES,
    parameter int HALF_CYCLES   = DEF_HALF_CYCLES,
    parameter int BIT_CYCLES    = DEF_BIT_CYCLES,
    parameter int WIN_LO        = DEF_WIN_LO,
    parameter int WIN_HI        = DEF_WIN_HI,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int LSB_FIRST     = 1,
    parameter int CNT_W         = 32
) (
    input logic                 clk,
    input logic                 rst,
    ir_frame_receiver_if.master bus
);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_LO     = CNT_W'(WIN_LO);
    localparam logic [CNT_W-1:0] W_HI     = CNT_W'(WIN_HI);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(START_TIMEOUT);
    localparam logic [2:0]       EDGES    = 3'(START_EDGES);
    localparam logic [4:0]       LAST_K   = 5'(DATA_BITS - 1);

    state_t               state, nxt;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [2:0]           ecnt, ecnt_n;
    logic [4:0]           k, k_n;
    logic                 seen, seen_n;
    logic [DATA_BITS-1:0] sh, sh_n, data_q;
    logic [4:0]           err_q;
    logic                 fall, rise;
    int                   bi;

    ir_edge_sync u_sync (.clk(clk), .rst(rst), .d(bus.sda), .fall(fall), .rise(rise));

    assign bi = idx(int'(k), DATA_BITS, LSB_FIRST);

    // next-state and datapath updates; the window test excludes the bit's last cycle so sh is final there
    always_comb begin
        nxt    = state;
        cnt_n  = cnt + 1'b1;
        ecnt_n = ecnt;
        k_n    = k;
        seen_n = seen;
        sh_n   = sh;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) begin
                    ecnt_n = 3'd1;
                    nxt    = (START_EDGES == 1) ? ALIGN : START;
                end
            end
            START: begin
                if (fall) begin
                    cnt_n  = '0;
                    ecnt_n = ecnt + 1'b1;
                    nxt    = (ecnt_n == EDGES) ? ALIGN : START;
                end else if (cnt == TIMEOUT) begin
                    nxt = IDLE;
                end
            end
            ALIGN: begin
                if (cnt == HALF_END) begin
                    nxt    = DATA;
                    cnt_n  = '0;
                    k_n    = '0;
                    seen_n = 1'b0;
                end
            end
            DATA: begin
                if (cnt > W_LO && cnt < W_HI && (fall || rise)) begin
                    seen_n = 1'b1;
                    for (int i = 0; i < DATA_BITS; i++)
                        if (i == bi) sh_n[i] = fall;
                end
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (!seen) nxt = ERR;
                    else if (k == LAST_K) nxt = DONE;
                    else begin
                        k_n    = k + 1'b1;
                        seen_n = 1'b0;
                    end
                end
            end
            default: begin
                cnt_n = '0;
                nxt   = IDLE;
            end
        endcase
    end

    // state, counters and result registers; results load as the FSM enters DONE/ERR so they line up with the pulse
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ecnt   <= '0;
            k      <= '0;
            seen   <= 1'b0;
            sh     <= '0;
            data_q <= '0;
            err_q  <= '0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_n;
            ecnt   <= ecnt_n;
            k      <= k_n;
            seen   <= seen_n;
            sh     <= sh_n;
            data_q <= (nxt == DONE) ? sh_n : data_q;
            err_q  <= (nxt == ERR) ? k : err_q;
        end

    assign bus.rx_data  = data_q;
    assign bus.err_bit  = err_q;
    assign bus.rx_valid = state == DONE;
    assign bus.rx_error = state == ERR;
    assign bus.busy     = state != IDLE;
endmodule
